// File: rtl/servo_pwm_capture.sv
// Servo-style PWM input capture: measures high time and rise-to-rise period in clk cycles
// and exposes them, with status flags and a level interrupt, on an Avalon-MM slave.
module servo_pwm_capture #(
    parameter int CNT_W          = 24,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pwm_in,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t            state;
    logic              s1, s2, s3;
    logic [CNT_W-1:0]  wcnt, pcnt;
    logic [CNT_W-1:0]  width_r, period_r;
    logic [IDLE_W-1:0] idle_cnt;
    logic              en, irq_en;
    logic              valid, timeout, overrun;

    logic              rise, fall, edge_any;
    logic              wr_ctrl, wr_status, rd_width;
    logic              publish, watchdog_hit;
    logic [IDLE_W-1:0] idle_inc;
    logic              unused_wdata;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign rise      = s2 & ~s3;
    assign fall      = ~s2 & s3;
    assign edge_any  = rise | fall;
    assign wr_ctrl   = avs_write && (avs_address == 2'd0);
    assign wr_status = avs_write && (avs_address == 2'd1);
    assign rd_width  = avs_read  && (avs_address == 2'd2);

    assign idle_inc     = idle_cnt + IDLE_W'(1);
    assign publish      = en && (state == HIGH) && fall;
    assign watchdog_hit = en && (state != IDLE) && !edge_any && (idle_inc == IDLE_LIMIT);
    assign unused_wdata = ^avs_writedata[31:3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wcnt     <= '0;
            pcnt     <= '0;
            idle_cnt <= '0;
            width_r  <= '0;
            period_r <= '0;
            en       <= 1'b0;
            irq_en   <= 1'b0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en     <= avs_writedata[0];
                irq_en <= avs_writedata[1];
            end

            // Hardware sets take priority over software clears on every flag.
            if (publish)
                valid <= 1'b1;
            else if (rd_width)
                valid <= 1'b0;

            if (watchdog_hit)
                timeout <= 1'b1;
            else if (wr_status && avs_writedata[1])
                timeout <= 1'b0;

            if (publish && valid && !rd_width)
                overrun <= 1'b1;
            else if (wr_status && avs_writedata[2])
                overrun <= 1'b0;

            if (!en) begin
                state    <= IDLE;
                wcnt     <= '0;
                pcnt     <= '0;
                idle_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        idle_cnt <= '0;
                        if (rise) begin
                            state <= HIGH;
                            wcnt  <= CNT_W'(1);
                            pcnt  <= CNT_W'(1);
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            width_r  <= wcnt;
                            pcnt     <= sat_inc(pcnt);
                            idle_cnt <= '0;
                            state    <= LOW;
                        end else if (watchdog_hit) begin
                            wcnt     <= '0;
                            pcnt     <= '0;
                            idle_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            wcnt     <= sat_inc(wcnt);
                            pcnt     <= sat_inc(pcnt);
                            idle_cnt <= idle_inc;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            period_r <= pcnt;
                            wcnt     <= CNT_W'(1);
                            pcnt     <= CNT_W'(1);
                            idle_cnt <= '0;
                            state    <= HIGH;
                        end else if (watchdog_hit) begin
                            wcnt     <= '0;
                            pcnt     <= '0;
                            idle_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            pcnt     <= sat_inc(pcnt);
                            idle_cnt <= idle_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= '0;
            irq          <= 1'b0;
        end else begin
            irq <= irq_en & (valid | timeout);
            if (avs_read) begin
                case (avs_address)
                    2'd0:    avs_readdata <= {30'd0, irq_en, en};
                    2'd1:    avs_readdata <= {28'd0, s2, overrun, timeout, valid};
                    2'd2:    avs_readdata <= 32'(width_r);
                    default: avs_readdata <= 32'(period_r);
                endcase
            end
        end
    end

endmodule

// File: doc/servo_pwm_capture.md
# servo_pwm_capture

Measures an external servo-style PWM input (RC receiver channel or feedback loop-back of a servo_pwm output) and reports high-time and period in clock cycles to the HPS over an Avalon-MM slave. It is the receive-side counterpart of the servo PWM generators in soc_system. It sits on the lightweight HPS-to-FPGA bridge, with `pwm_in` exported as a conduit.

## Interface
- `CNT_W`, 24: width of the width/period counters and registers. Values saturate at 2^CNT_W-1.
- `TIMEOUT_CYCLES`, 2500000: cycles without an edge before signal loss is declared (50 ms at 50 MHz).
- `clk`  in  1  system clock. All logic is in this domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pwm_in`  in  1  asynchronous PWM input (conduit).
- `avs_address`  in  2  word address.
- `avs_read`  in  1  read strobe.
- `avs_write`  in  1  write strobe.
- `avs_writedata`  in  32  write data.
- `avs_readdata`  out  32  read data, registered, readLatency = 1.
- `irq`  out  1  level interrupt.

## Operation
- Input path: 2-flop synchronizer (s1, s2), then s3 as a delay register.
  - rise = s2 & ~s3
  - fall = ~s2 & s3
- Registers; all bits not listed read as 0:
  - 0 CTRL (RW): bit0 EN, bit1 IRQ_EN.
  - 1 STATUS: bit0 VALID (RO), bit1 TIMEOUT (W1C), bit2 OVERRUN (W1C), bit3 LEVEL (RO, = s2).
  - 2 WIDTH (RO): last high time in cycles.
  - 3 PERIOD (RO): last rise-to-rise time in cycles.
- Reading WIDTH clears VALID. Writes to WIDTH and PERIOD are ignored.
- FSM states:
  - IDLE: wait for rise while EN=1. On rise → HIGH, wcnt=1, pcnt=1, idle counter cleared.
  - HIGH: wcnt++ and pcnt++ each cycle.
    - On fall: WIDTH←wcnt, VALID←1, → LOW.
    - If VALID was already 1 and is not being cleared this cycle, set OVERRUN.
  - LOW: pcnt++ each cycle.
    - On rise: PERIOD←pcnt, wcnt=1, pcnt=1, → HIGH.
- Watchdog, in HIGH or LOW: idle counter increments each cycle with no edge and resets on any edge. When it reaches TIMEOUT_CYCLES: TIMEOUT←1, → IDLE. No WIDTH or PERIOD update occurs.
- Counters saturate; they never wrap.
- EN cleared: FSM → IDLE on the next edge and all counters are zeroed. WIDTH, PERIOD and STATUS are retained.
- The first rise after entering IDLE never updates PERIOD.
- `irq` = IRQ_EN & (VALID | TIMEOUT), registered.

## Timing
- Reset values: all registers, counters and `avs_readdata` = 0; `irq` = 0; FSM = IDLE; synchronizer flops = 0.
- Edge detection: a `pwm_in` transition sampled at edge k produces rise or fall at k+1, combinational from s2/s3.
- Register update: WIDTH, PERIOD and flags update at edge k+2.
- Measured width equals the high time of `pwm_in` rounded to a whole number of cycles. Synchronizer delay cancels because it is identical on both edges.
- Read data: `avs_readdata` is valid the cycle after `avs_read`. VALID clears on the same edge that captures the WIDTH read data.
- Simultaneous publish and WIDTH read: VALID stays 1 and OVERRUN is not set. The read returns the old WIDTH.
- Simultaneous W1C and hardware set of TIMEOUT or OVERRUN: the set wins.
- `irq` follows a flag change by 1 cycle.

## Test plan
1. Pulse train, EN=1, CNT_W=24: 1.5 ms high / 20 ms period at 50 MHz.
   - WIDTH = 75000, PERIOD = 1000000.
   - VALID sets once per period. PERIOD is not written on the first rise.
2. Short pulses: 3-cycle high, 10-cycle period pulses.
   - WIDTH = 3, PERIOD = 10.
   - OVERRUN = 1 after the second pulse, since WIDTH was never read.
   - Reading WIDTH clears VALID. Writing 0x4 to STATUS clears OVERRUN.
3. Loss of signal, TIMEOUT_CYCLES=100:
   - Hold `pwm_in` high for 150 cycles: TIMEOUT = 1, FSM in IDLE, WIDTH unchanged. With IRQ_EN=1, `irq` = 1.
   - Write 0x2 to STATUS: TIMEOUT = 0 and `irq` = 0.
4. Saturation, CNT_W=8, TIMEOUT_CYCLES=1000: 300-cycle pulse gives WIDTH = 255.
5. Disable mid-pulse, then reset mid-pulse:
   - Clear EN during HIGH: no WIDTH update at the following fall.
   - Re-enable: the next full pulse is measured correctly.
   - Assert `reset_n`=0 during HIGH: all registers read 0 immediately.
6. Simultaneous publish and WIDTH read: fall detected in the same cycle as a WIDTH read.
   - Old WIDTH is returned. VALID stays 1, OVERRUN stays 0.
   - The next WIDTH read returns the new value.
